// File: rtl/m_dram_arbiter_pkg.sv
// Shared definitions for the two-master DRAM arbiter: FSM states, port IDs,
// FUNCT3 access-size codes and the latched request record.
package m_dram_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ISSUE = 3'd1,
        ARB_WAIT1 = 3'd2,
        ARB_WAIT  = 3'd3,
        ARB_DONE  = 3'd4
    } arb_state_t;

    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        le;
        logic [2:0]  ctrl;
    } arb_req_t;

endpackage

// File: rtl/m_dram_arb_pick.sv
// Port selection: port 0 wins unless port 1 is alone or has been starved
// for STARVE_MAX consecutive port-0 grants.
module m_dram_arb_pick
    import m_dram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic [7:0] i_starve,
    output logic       o_grant_valid,
    output logic       o_owner
);

    logic w_starved;

    assign w_starved     = (i_starve >= 8'(STARVE_MAX));
    assign o_grant_valid = i_req0 | i_req1;
    assign o_owner       = (i_req1 & (~i_req0 | w_starved)) ? ARB_P1 : ARB_P0;

endmodule

// File: rtl/m_dram_arbiter.sv
// Two-master DRAM port arbiter/sequencer: latches the winner, strobes it to
// the controller for one cycle, waits for completion and returns read data.
module m_dram_arbiter
    import m_dram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic        CLK,
    input  logic        RST_X,
    input  logic [31:0] w_p0_addr,
    input  logic [31:0] w_p0_wdata,
    input  logic        w_p0_we,
    input  logic        w_p0_le,
    input  logic [2:0]  w_p0_ctrl,
    output logic [31:0] w_p0_odata,
    output logic        w_p0_busy,
    input  logic [31:0] w_p1_addr,
    input  logic [31:0] w_p1_wdata,
    input  logic        w_p1_we,
    input  logic        w_p1_le,
    input  logic [2:0]  w_p1_ctrl,
    output logic [31:0] w_p1_odata,
    output logic        w_p1_busy,
    output logic        w_p1_ack,
    output logic [31:0] w_dram_addr,
    output logic [31:0] w_dram_wdata,
    output logic        w_dram_we,
    output logic        w_dram_le,
    output logic [2:0]  w_dram_ctrl,
    input  logic [31:0] w_dram_odata,
    input  logic        w_dram_busy,
    output logic [1:0]  w_grant
);

    arb_state_t       r_state, w_next;
    arb_req_t         r_req;
    arb_req_t         w_p0_req, w_p1_req;
    logic             r_owner;
    logic [1:0][31:0] r_rdata;
    logic [7:0]       r_starve;

    logic w_req0, w_req1, w_valid, w_owner, w_go, w_active;

    assign w_req0 = w_p0_we | w_p0_le;
    assign w_req1 = w_p1_we | w_p1_le;

    // A simultaneous we+le is a write; the load request is dropped here.
    assign w_p0_req = '{w_p0_addr, w_p0_wdata, w_p0_we, w_p0_le & ~w_p0_we, w_p0_ctrl};
    assign w_p1_req = '{w_p1_addr, w_p1_wdata, w_p1_we, w_p1_le & ~w_p1_we, w_p1_ctrl};

    m_dram_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .i_req0        (w_req0),
        .i_req1        (w_req1),
        .i_starve      (r_starve),
        .o_grant_valid (w_valid),
        .o_owner       (w_owner)
    );

    assign w_go = (r_state == ARB_IDLE) & w_valid & ~w_dram_busy;

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) r_state <= ARB_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_req    <= '0;
            r_owner  <= ARB_P0;
            r_rdata  <= '0;
            r_starve <= 8'd0;
        end else begin
            if (w_go) begin
                r_req   <= (w_owner == ARB_P1) ? w_p1_req : w_p0_req;
                r_owner <= w_owner;
                if (w_owner == ARB_P1)
                    r_starve <= 8'd0;
                else if (w_req1 && (r_starve < 8'(STARVE_MAX)))
                    r_starve <= r_starve + 8'd1;
            end
            if ((r_state == ARB_WAIT) && !w_dram_busy && r_req.le)
                r_rdata[r_owner] <= w_dram_odata;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_active     = (r_state != ARB_IDLE);
        w_dram_addr  = 32'd0;
        w_dram_wdata = 32'd0;
        w_dram_ctrl  = 3'd0;
        w_dram_we    = 1'b0;
        w_dram_le    = 1'b0;
        w_p0_busy    = 1'b1;
        w_p1_busy    = 1'b1;
        w_p1_ack     = 1'b0;
        if (w_active) begin
            w_dram_addr  = r_req.addr;
            w_dram_wdata = r_req.wdata;
            w_dram_ctrl  = r_req.ctrl;
        end
        case (r_state)
            ARB_IDLE: begin
                w_p0_busy = w_req0 | w_dram_busy;
                w_p1_busy = w_req1 | w_dram_busy;
                if (w_go) w_next = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                w_dram_we = r_req.we;
                w_dram_le = r_req.le;
                w_next    = ARB_WAIT1;
            end
            // Controller raises busy one cycle after the strobe; skip that gap.
            ARB_WAIT1: w_next = ARB_WAIT;
            ARB_WAIT:  if (!w_dram_busy) w_next = ARB_DONE;
            ARB_DONE: begin
                w_p0_busy = (r_owner != ARB_P0);
                w_p1_busy = (r_owner != ARB_P1);
                w_p1_ack  = (r_owner == ARB_P1);
                w_next    = ARB_IDLE;
            end
            default: w_next = ARB_IDLE;
        endcase
    end

    assign w_grant    = {w_active, w_active & r_owner};
    assign w_p0_odata = r_rdata[0];
    assign w_p1_odata = r_rdata[1];

endmodule
